key_sequencer: RTL and testbench

Keyboard matrix scheduler between the serial keyboard receiver and the CPU key-read decode at 0x2000-0x27ff. Buffers received ASCII bytes in a FIFO, translates each byte to a matrix key index (plus SHIFT where needed), and plays keys one at a time as timed press / hold / release sequences. The ROM scan loop therefore sees every keystroke even when bytes arrive back-to-back at 115200 baud.

---
 rtl/key_sequencer_if.sv | 29 ++
 rtl/key_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_key_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_sequencer_if.sv
// key_sequencer_if: signal bundle between the UART receiver / CPU read decode
// (master side) and the key sequencer (slave side).
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data. There is no
// ready back to the sender. The sequencer either buffers the byte or drops it
// and raises the sticky overflow flag; fifo_full is advisory only. rd_key is
// a one-cycle read strobe: key_out is valid the cycle after it and holds
// until the next rd_key.
interface key_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_key;
  logic [5:0] key_addr;
  logic [7:0] key_out;
  logic       fifo_full;
  logic       busy;
  logic       overflow;
  logic [2:0] state_dbg;

  modport master (
    output rx_data, rx_valid, rd_key, key_addr,
    input  key_out, fifo_full, busy, overflow, state_dbg
  );

  modport slave (
    input  rx_data, rx_valid, rd_key, key_addr,
    output key_out, fifo_full, busy, overflow, state_dbg
  );
endinterface

// File: rtl/key_sequencer.sv
// key_sequencer: buffers received ASCII bytes, translates each to a keyboard
// matrix index (plus SHIFT when needed) and plays them one at a time as timed
// press / hold / release sequences for the CPU key-read decode.
// Optional feature macro KEY_SEQ_SHIFT_LEAD_EN: when defined, shifted keys get
// a LEAD phase where SHIFT is pressed alone before the key goes down.
module key_sequencer #(
  parameter int HOLD_CYCLES = 400000,
  parameter int GAP_CYCLES  = 400000,
  parameter int LEAD_CYCLES = 100000,
  parameter int FIFO_AW     = 4
) (
  input  logic           clk,
  input  logic           resetn,
  key_sequencer_if.slave bus
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_P  = (MAX_HG > LEAD_CYCLES) ? MAX_HG : LEAD_CYCLES;
  localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  // A zero-length phase is stretched to one cycle.
  localparam logic [CW-1:0] HOLD_LD = (HOLD_CYCLES > 1) ? CW'(HOLD_CYCLES - 1) : '0;
  localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 1) ? CW'(GAP_CYCLES - 1) : '0;
`ifdef KEY_SEQ_SHIFT_LEAD_EN
  localparam logic [CW-1:0] LEAD_LD = (LEAD_CYCLES > 1) ? CW'(LEAD_CYCLES - 1) : '0;
`endif
  localparam logic [5:0]         SHIFT_KEY = 6'd53;
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_HOLD   = 3'd2,
    S_GAP    = 3'd3
`ifdef KEY_SEQ_SHIFT_LEAD_EN
    , S_LEAD = 3'd4
`endif
  } state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     count, count_next;
  logic [7:0]           cur_byte;
  logic                 empty, full_now, pop, push, drop;
  logic [5:0]           map_key;
  logic                 map_shift, map_ok;
  logic                 shift_on, key_on, key_hit;
  logic                 fifo_full_q, busy_q, overflow_q;
  logic [7:0]           key_out_q;

  assign empty    = (count == '0);
  assign full_now = (count == DEPTH_CNT);
  assign pop      = (state == S_IDLE) && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push     = bus.rx_valid && (!full_now || pop);
  assign drop     = bus.rx_valid && !push;

  // ASCII to matrix key translation of the byte currently being played.
  always_comb begin
    map_key   = '0;
    map_shift = 1'b0;
    map_ok    = 1'b1;
    if (cur_byte >= 8'h41 && cur_byte <= 8'h5A)      map_key = 6'(cur_byte - 8'h40);
    else if (cur_byte >= 8'h61 && cur_byte <= 8'h7A) map_key = 6'(cur_byte - 8'h60);
    else if (cur_byte >= 8'h30 && cur_byte <= 8'h39) map_key = 6'(cur_byte - 8'h10);
    else begin
      case (cur_byte)
        8'h0A, 8'h0D: map_key = 6'd48;
        8'h08, 8'h7F: map_key = 6'd29;
        8'h1B:        map_key = 6'd49;
        8'h20:        map_key = 6'd31;
        8'h3B:        map_key = 6'd42;  // ;
        8'h3A:        map_key = 6'd43;  // :
        8'h2C:        map_key = 6'd44;  // ,
        8'h3D:        map_key = 6'd45;  // =
        8'h2E:        map_key = 6'd46;  // .
        8'h2F:        map_key = 6'd47;  // /
        8'h5F: begin map_key = 6'd32; map_shift = 1'b1; end  // _
        8'h21: begin map_key = 6'd33; map_shift = 1'b1; end  // !
        8'h22: begin map_key = 6'd34; map_shift = 1'b1; end  // double quote
        8'h23: begin map_key = 6'd35; map_shift = 1'b1; end  // #
        8'h24: begin map_key = 6'd36; map_shift = 1'b1; end  // $
        8'h25: begin map_key = 6'd37; map_shift = 1'b1; end  // %
        8'h26: begin map_key = 6'd38; map_shift = 1'b1; end  // &
        8'h27: begin map_key = 6'd39; map_shift = 1'b1; end  // apostrophe
        8'h28: begin map_key = 6'd40; map_shift = 1'b1; end  // (
        8'h29: begin map_key = 6'd41; map_shift = 1'b1; end  // )
        8'h2B: begin map_key = 6'd42; map_shift = 1'b1; end  // +
        8'h2A: begin map_key = 6'd43; map_shift = 1'b1; end  // *
        8'h3C: begin map_key = 6'd44; map_shift = 1'b1; end  // <
        8'h2D: begin map_key = 6'd45; map_shift = 1'b1; end  // -
        8'h3E: begin map_key = 6'd46; map_shift = 1'b1; end  // >
        8'h3F: begin map_key = 6'd47; map_shift = 1'b1; end  // ?
        default: map_ok = 1'b0;
      endcase
    end
  end

  // Sequencer next state and phase counter reload / count-down.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: if (!empty) state_next = S_DECODE;
      S_DECODE: begin
        if (!map_ok) state_next = S_IDLE;
`ifdef KEY_SEQ_SHIFT_LEAD_EN
        else if (map_shift) begin state_next = S_LEAD; cnt_next = LEAD_LD; end
`endif
        else begin state_next = S_HOLD; cnt_next = HOLD_LD; end
      end
`ifdef KEY_SEQ_SHIFT_LEAD_EN
      S_LEAD: begin
        if (cnt == '0) begin state_next = S_HOLD; cnt_next = HOLD_LD; end
        else cnt_next = cnt - 1'b1;
      end
`endif
      S_HOLD: begin
        if (cnt == '0) begin state_next = S_GAP; cnt_next = GAP_LD; end
        else cnt_next = cnt - 1'b1;
      end
      S_GAP: begin
        if (cnt == '0) state_next = S_IDLE;
        else cnt_next = cnt - 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Matrix lookup: only the current key and SHIFT can be down.
  always_comb begin
    key_on   = (state == S_HOLD);
    shift_on = (state == S_HOLD) && map_shift;
`ifdef KEY_SEQ_SHIFT_LEAD_EN
    if (state == S_LEAD) shift_on = 1'b1;
`endif
    key_hit = (key_on && (bus.key_addr == map_key)) ||
              (shift_on && (bus.key_addr == SHIFT_KEY));
  end

  // Sequencer state and phase counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // FIFO pointers, popped byte and registered status flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur_byte    <= '0;
      fifo_full_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        cur_byte <= mem[rd_ptr];
      end
      count       <= count_next;
      fifo_full_q <= (count_next == DEPTH_CNT);
      busy_q      <= (state_next != S_IDLE) || (count_next != '0);
      overflow_q  <= overflow_q | drop;
    end
  end

  // FIFO storage; contents need no reset because the count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  // CPU read data latched on each read strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         key_out_q <= 8'hFF;
    else if (bus.rd_key) key_out_q <= key_hit ? 8'hFE : 8'hFF;
  end

  assign bus.key_out   = key_out_q;
  assign bus.fifo_full = fifo_full_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_key_sequencer.sv
// tb_key_sequencer: directed bench for key_sequencer with HOLD=4, GAP=2,
// LEAD=2, FIFO_AW=2. Key activity is captured as one bit per clock
// (1 = key_out read FE) while rd_key is held high on one address.
module tb_key_sequencer;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int LEAD = 2;
  localparam int AW   = 2;

  // Plain keystroke: HOLD entered 3 edges after the strobe, read lags 1 clock.
  localparam logic [63:0] PLAIN = 64'h78;
`ifdef KEY_SEQ_SHIFT_LEAD_EN
  localparam logic [63:0] SH_KEY   = 64'h1E0;
  localparam logic [63:0] SH_SHIFT = 64'h1F8;
`else
  localparam logic [63:0] SH_KEY   = 64'h78;
  localparam logic [63:0] SH_SHIFT = 64'h78;
`endif

  localparam int NT = 15;
  localparam logic [7:0] T_BYTE [NT] = '{8'h7A, 8'h30, 8'h39, 8'h0D, 8'h0A, 8'h7F, 8'h08,
                                        8'h1B, 8'h20, 8'h3B, 8'h3B, 8'h2F, 8'h3F, 8'h3F, 8'h5F};
  localparam logic [5:0] T_ADDR [NT] = '{6'd26, 6'd32, 6'd41, 6'd48, 6'd48, 6'd29, 6'd29,
                                        6'd49, 6'd31, 6'd42, 6'd53, 6'd47, 6'd47, 6'd53, 6'd32};
  localparam logic [63:0] T_EXP [NT] = '{PLAIN, PLAIN, PLAIN, PLAIN, PLAIN, PLAIN, PLAIN,
                                        PLAIN, PLAIN, PLAIN, 64'h0, PLAIN, SH_KEY, SH_SHIFT, SH_KEY};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  tx_q[$];
  logic [63:0] rec, rec_full;

  // Clock
  always #5 clk = ~clk;

  key_sequencer_if bus ();

  key_sequencer #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .LEAD_CYCLES(LEAD),
    .FIFO_AW    (AW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe the queued bytes on consecutive cycles while reading one key address.
  task automatic run(input logic [5:0] addr, input int n,
                     output logic [63:0] r, output logic [63:0] rf);
    r  = '0;
    rf = '0;
    bus.key_addr = addr;
    bus.rd_key   = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (tx_q.size() > 0) begin
        bus.rx_data  = tx_q.pop_front();
        bus.rx_valid = 1'b1;
      end else begin
        bus.rx_valid = 1'b0;
      end
      tick();
      r[i]  = (bus.key_out === 8'hFE);
      rf[i] = (bus.fifo_full === 1'b1);
    end
    bus.rx_valid = 1'b0;
    bus.rd_key   = 1'b0;
  endtask

  // Bounded wait for the sequencer to drain; an expired bound fails the check.
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {63'b0, bus.busy}, 64'h0);
    tick();
  endtask

  // Send one byte and advance to the first HOLD cycle of its keystroke.
  task automatic send_to_hold(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.rd_key   = 1'b0;
    bus.key_addr = '0;

    // Reset values
    repeat (2) tick();
    check("rst_key_out",   {56'b0, bus.key_out}, 64'hFF);
    check("rst_fifo_full", {63'b0, bus.fifo_full}, 64'h0);
    check("rst_busy",      {63'b0, bus.busy}, 64'h0);
    check("rst_overflow",  {63'b0, bus.overflow}, 64'h0);
    resetn = 1'b1;
    repeat (2) tick();

    // 'A': key 1 for 4 clocks, SHIFT never
    tx_q = '{8'h41};
    run(6'd1, 16, rec, rec_full);
    check("A_key1", rec, PLAIN);
    wait_idle("A1");
    tx_q = '{8'h41};
    run(6'd53, 16, rec, rec_full);
    check("A_shift", rec, 64'h0);
    wait_idle("A53");

    // '!': key 33 with SHIFT
    tx_q = '{8'h21};
    run(6'd33, 16, rec, rec_full);
    check("bang_key33", rec, SH_KEY);
    wait_idle("bang33");
    tx_q = '{8'h21};
    run(6'd53, 16, rec, rec_full);
    check("bang_shift", rec, SH_SHIFT);
    wait_idle("bang53");

    // 'x' then '5' back-to-back: key 24, then key 37 one period later
    tx_q = '{8'h78, 8'h35};
    run(6'd24, 24, rec, rec_full);
    check("x5_key24", rec, 64'h78);
    wait_idle("x5a");
    tx_q = '{8'h78, 8'h35};
    run(6'd37, 24, rec, rec_full);
    check("x5_key37", rec, 64'h7800);
    wait_idle("x5b");

    // Translation table
    for (int t = 0; t < NT; t++) begin
      tx_q = '{T_BYTE[t]};
      run(T_ADDR[t], 16, rec, rec_full);
      check($sformatf("map_%02h_k%0d", T_BYTE[t], T_ADDR[t]), rec, T_EXP[t]);
      wait_idle("map");
    end

    // key_out holds its value between read strobes
    send_to_hold(8'h41);
    bus.key_addr = 6'd1;
    bus.rd_key   = 1'b1;
    tick();
    bus.rd_key   = 1'b0;
    check("rd_hit", {56'b0, bus.key_out}, 64'hFE);
    repeat (10) tick();
    check("rd_held", {56'b0, bus.key_out}, 64'hFE);
    bus.rd_key = 1'b1;
    tick();
    bus.rd_key = 1'b0;
    check("rd_after", {56'b0, bus.key_out}, 64'hFF);
    wait_idle("rd");

    // Six back-to-back bytes into a 4-deep FIFO: one popped, four kept, one dropped
    tx_q = '{8'h61, 8'h61, 8'h61, 8'h61, 8'h61, 8'h61};
    run(6'd1, 48, rec, rec_full);
    check("ovf_keystrokes", rec, 64'h0000_0078_7878_7878);
    check("ovf_fifo_full", rec_full, 64'h1F0);
    check("ovf_flag", {63'b0, bus.overflow}, 64'h1);
    wait_idle("ovf");
    check("ovf_full_clear", {63'b0, bus.fifo_full}, 64'h0);

    // Unmapped 0x01 then 'B'
    tx_q = '{8'h01, 8'h42};
    run(6'd2, 16, rec, rec_full);
    check("unmap_key2", rec, 64'h1E0);
    wait_idle("unmap2");
    tx_q = '{8'h01, 8'h42};
    run(6'd1, 16, rec, rec_full);
    check("unmap_key1", rec, 64'h0);
    wait_idle("unmap1");
    check("ovf_sticky", {63'b0, bus.overflow}, 64'h1);

    // Reset during HOLD of 'C'
    send_to_hold(8'h43);
    bus.key_addr = 6'd3;
    bus.rd_key   = 1'b1;
    tick();
    bus.rd_key   = 1'b0;
    check("C_pressed", {56'b0, bus.key_out}, 64'hFE);
    resetn = 1'b0;
    #1;
    check("C_rst_key_out",  {56'b0, bus.key_out}, 64'hFF);
    check("C_rst_busy",     {63'b0, bus.busy}, 64'h0);
    check("C_rst_overflow", {63'b0, bus.overflow}, 64'h0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    bus.rd_key = 1'b1;
    tick();
    bus.rd_key = 1'b0;
    check("C_after_key3", {56'b0, bus.key_out}, 64'hFF);
    check("C_after_busy", {63'b0, bus.busy}, 64'h0);
    check("C_after_full", {63'b0, bus.fifo_full}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
